// File: rtl/modulo_leitor_teclado_matriz.sv
// Scanned-matrix keypad reader: drives one column low at a time, debounces the
// first key found and reports its code with a one-cycle valid pulse.
module modulo_leitor_teclado_matriz #(
    parameter int N_COLS    = 4,
    parameter int N_ROWS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N_ROWS-1:0] k_line,
    output logic [N_COLS-1:0] k_col,
    output logic [3:0]        key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(N_COLS);
    localparam int RW = $clog2(N_ROWS);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(N_COLS - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_TICKS - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t            state;
    logic [N_ROWS-1:0] sync1;
    logic [N_ROWS-1:0] sl;
    logic [PW-1:0]     presc;
    logic              tick;
    logic [CW-1:0]     col;
    logic [CW-1:0]     col_adv;
    logic [N_COLS-1:0] k_col_adv;
    logic [RW-1:0]     r;
    logic [RW-1:0]     low_row;
    logic [RW-1:0]     accept_row;
    logic              any_low;
    logic              r_low;
    logic [DW-1:0]     deb_cnt;
    logic [3:0]        code_calc;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1 <= '1;
            sl    <= '1;
        end else begin
            sync1 <= k_line;
            sl    <= sync1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    assign tick = (presc == PRESC_LAST);

    // Lowest-index active row wins when several keys share the scanned column.
    always_comb begin
        low_row = '0;
        any_low = 1'b0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (!sl[i] && !any_low) begin
                low_row = RW'(i);
                any_low = 1'b1;
            end
        end
    end

    always_comb begin
        col_adv   = (col == COL_LAST) ? '0 : col + 1'b1;
        k_col_adv = '1;
        for (int unsigned i = 0; i < N_COLS; i++) begin
            if (CW'(i) == col_adv) begin
                k_col_adv[i] = 1'b0;
            end
        end
    end

    assign r_low      = !sl[r];
    assign accept_row = (state == SCAN) ? low_row : r;
    assign code_calc  = 4'(accept_row) * 4'(N_COLS) + 4'(col);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= SCAN;
            col       <= '0;
            k_col     <= {{(N_COLS-1){1'b1}}, 1'b0};
            r         <= '0;
            deb_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            r <= low_row;
                            if (DEB_TICKS == 1) begin
                                key_code  <= code_calc;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= DW'(1);
                                state   <= DEBOUNCE;
                            end
                        end else begin
                            col   <= col_adv;
                            k_col <= k_col_adv;
                        end
                    end
                    DEBOUNCE: begin
                        if (r_low) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_code  <= code_calc;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                            col     <= col_adv;
                            k_col   <= k_col_adv;
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!r_low) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_held <= 1'b0;
                                deb_cnt  <= '0;
                                col      <= col_adv;
                                k_col    <= k_col_adv;
                                state    <= SCAN;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: doc/modulo_leitor_teclado_matriz.md
Name: modulo_leitor_teclado_matriz

Overview:
- Scanned-matrix keypad reader; the input-side counterpart of the LED-matrix column scan.
- Drives one keypad column low at a time and reads the row lines back.
- Debounces a detected key and emits a coordinate/key code with a one-cycle valid pulse.
- Its output replaces slide-switch coordinate entry (hh2) and confirmation in the game top level.

Parameters:
N_COLS, 4, number of keypad columns driven (2..4)
N_ROWS, 4, number of keypad row lines read (2..4)
SCAN_DIV, 50000, clk cycles per column step (scan tick period); minimum 2
DEB_TICKS, 8, consecutive matching scan ticks required to accept a press or a release; minimum 1

Ports:
clk  input  1  system clock
clr  input  1  reset, asynchronous, active-high
k_line  input  N_ROWS  keypad row lines, active-low (pulled up externally), asynchronous to clk
k_col  output  N_COLS  column drive, active-low, exactly one bit low at any time
key_code  output  4  accepted key code = row*N_COLS + col; holds its value until the next accepted press
key_valid  output  1  one-cycle pulse when a press is accepted
key_held  output  1  high from press acceptance until release is accepted

Behaviour:
- Reset (clr=1, asynchronous) forces:
  - k_col = all ones except bit 0 low (column 0 driven).
  - key_code = 0, key_valid = 0, key_held = 0.
  - Prescaler, debounce counter, column index and candidate row = 0.
  - Both synchronizer stages = all ones.
  - State = SCAN.
  - Reset mid-debounce or mid-hold discards the key; no valid pulse is produced.
- Synchronizer: k_line passes through 2 flops; all decisions use the second stage (sl).
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = 1 for the single cycle where count = SCAN_DIV-1.
  - Free-running in every state.
- Column index col: 0..N_COLS-1; k_col is the registered one-cold decode of col.
- State SCAN:
  - On tick, if any sl bit is low: candidate row r = lowest-index low bit; col is frozen; deb_cnt = 1. If DEB_TICKS = 1, go directly to the accept action; else go to DEBOUNCE.
  - On tick with sl all ones: col advances, wrapping N_COLS-1 -> 0.
- State DEBOUNCE, on tick:
  - sl[r] low: deb_cnt+1. When deb_cnt reaches DEB_TICKS, take the accept action.
  - sl[r] high: deb_cnt = 0; col advances; back to SCAN.
  - Other row bits are ignored.
- Accept action (single clock edge):
  - key_code <= r*N_COLS + col.
  - key_valid <= 1 for exactly the next cycle.
  - key_held <= 1.
  - deb_cnt = 0; go to HELD.
  - key_code and key_valid become visible in the same cycle.
- State HELD, col frozen, on tick:
  - sl[r] high: deb_cnt+1.
  - sl[r] low: deb_cnt = 0.
  - When deb_cnt reaches DEB_TICKS: key_held <= 0; col advances; go to SCAN.
  - Other keys pressed during HELD are ignored; no rollover and no repeat.
- Multiple keys in one column at first detection: lowest row index wins.
- Keys in different columns: the first column scanned wins.
- Width rule: key_code is zero-extended to 4 bits; N_COLS*N_ROWS <= 16 guarantees no truncation.
- Latency from a stable press of (r,c), with the scan currently on column c and the prescaler at 0:
  - 2 cycles synchronizer.
  - Plus DEB_TICKS*SCAN_DIV cycles to the accept edge.
  - Worst case adds (N_COLS-1)*SCAN_DIV for column wait.
- Bounce shorter than one tick period that ends high at the sample point restarts detection; no spurious pulse.

Test Plan (bench parameters SCAN_DIV=4, DEB_TICKS=3, N_COLS=N_ROWS=4, keypad model shorting row r to k_col[c]):
1. Reset:
   - Assert clr mid-cycle -> immediately k_col=4'b1110, key_code=0, key_valid=0, key_held=0.
   - Release clr with no keys -> k_col steps 1110,1101,1011,0111,1110, each held for 4 cycles.
2. Single press:
   - Press row 2 col 1 steadily -> exactly one key_valid pulse with key_code=9, then key_held=1.
   - k_col stays at 1101 while held.
   - Release -> key_held falls after 3 consecutive high ticks; scan resumes at column 2 (1011).
3. Bounce rejection:
   - Row 0 col 3 goes low for one tick, then high at the next tick -> no key_valid.
   - Scan continues; key_code unchanged (0).
4. Simultaneous keys:
   - Press row 1 and row 3 in col 0 together -> key_code=4, single pulse.
   - Press col 2 row 0 while col 0 is held -> ignored, no further pulse until release.
5. Release debounce:
   - During HELD, toggle row high for 2 ticks then low, repeated -> key_held stays 1 and no new pulse.
   - 3 clean high ticks -> key_held=0.
6. Reset mid-operation:
   - Assert clr during DEBOUNCE and again during HELD -> no key_valid; key_held=0.
   - Key still pressed after reset -> accepted anew with key_code correct.
